// File: rtl/rule_eval_seq.sv
// rule_eval_seq
// Evaluates the NT x ND rule grid of a two-input fuzzy controller from one
// snapshot of memberships. A snapshot (muT, muD, mode) is captured with each
// membership clamped to ONE. The block then streams one rule weight per
// cycle in row-major order, tracks the strongest rule and publishes it
// (w_max/idx_max) once the last rule has been handed over.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   snapshot offer / block idle and able to capture
//   muT, muD, mode      memberships (set k at [k*W +: W]); mode 0=min, 1=product
//   out_valid/out_ready rule-weight stream handshake
//   out_w, out_idx      weight of rule out_idx = i*ND + j
//   out_last            current beat is rule NT*ND-1
//   w_max, idx_max      strongest rule of the last completed snapshot
//   dbg_state           FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. A producer holding valid keeps its payload stable until the
// transfer; valid never depends on ready.
module rule_eval_seq #(
  parameter int W  = 16,
  parameter int NT = 3,
  parameter int ND = 3,
  parameter int IW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [NT*W-1:0] muT,
  input  logic [ND*W-1:0] muD,
  input  logic           mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_w,
  output logic [IW-1:0]  out_idx,
  output logic           out_last,
  output logic [W-1:0]   w_max,
  output logic [IW-1:0]  idx_max,
  output logic           dbg_state
);

  localparam int RW = (NT > 1) ? $clog2(NT) : 1;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [W-1:0]  ONE      = {1'b1, {(W-1){1'b0}}};
  localparam logic [IW-1:0] LAST_IDX = IW'(NT*ND-1);
  localparam logic [RW-1:0] LAST_ROW = RW'(NT-1);
  localparam logic [CW-1:0] LAST_COL = CW'(ND-1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [NT*W-1:0] mu_t_q, mu_t_d, mu_t_c;
  logic [ND*W-1:0] mu_d_q, mu_d_d, mu_d_c;
  logic            mode_q, mode_d;
  logic [RW-1:0]   row_q, row_d, nxt_row;
  logic [CW-1:0]   col_q, col_d, nxt_col;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_w_q, out_w_d;
  logic [IW-1:0]   out_idx_q, out_idx_d, nxt_idx;
  logic            out_last_q, out_last_d;
  logic [W-1:0]    run_max_q, run_max_d;
  logic [IW-1:0]   run_idx_q, run_idx_d;
  logic [W-1:0]    w_max_q, w_max_d;
  logic [IW-1:0]   idx_max_q, idx_max_d;
  logic            hs, beats_max;

  function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
    clamp = (v > ONE) ? ONE : v;
  endfunction

  // Both operands are <= ONE, so the shifted product never exceeds ONE.
  function automatic logic [W-1:0] tnorm(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic prod);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    if (prod) tnorm = W'(p >> (W-1));
    else      tnorm = (a < b) ? a : b;
  endfunction

  always_comb begin
    state_d     = state_q;
    mu_t_d      = mu_t_q;
    mu_d_d      = mu_d_q;
    mode_d      = mode_q;
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_w_d     = out_w_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    w_max_d     = w_max_q;
    idx_max_d   = idx_max_q;
    mu_t_c      = '0;
    mu_d_c      = '0;

    for (int k = 0; k < NT; k++) mu_t_c[k*W +: W] = clamp(muT[k*W +: W]);
    for (int k = 0; k < ND; k++) mu_d_c[k*W +: W] = clamp(muD[k*W +: W]);

    hs        = out_valid_q && out_ready;
    beats_max = out_w_q > run_max_q;  // strict: ties keep the lower index
    nxt_idx   = out_idx_q + 1'b1;
    if (col_q == LAST_COL) begin
      nxt_col = '0;
      nxt_row = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
    end else begin
      nxt_col = col_q + 1'b1;
      nxt_row = row_q;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Rule 0 is computed straight from the clamped inputs so it can be
          // presented the cycle after capture.
          state_d     = S_RUN;
          mu_t_d      = mu_t_c;
          mu_d_d      = mu_d_c;
          mode_d      = mode;
          row_d       = '0;
          col_d       = '0;
          out_valid_d = 1'b1;
          out_idx_d   = '0;
          out_last_d  = (LAST_IDX == '0);
          out_w_d     = tnorm(mu_t_c[W-1:0], mu_d_c[W-1:0], mode);
          run_max_d   = '0;
          run_idx_d   = '0;
        end
      end
      S_RUN: begin
        if (hs) begin
          if (out_last_q) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            w_max_d     = beats_max ? out_w_q   : run_max_q;
            idx_max_d   = beats_max ? out_idx_q : run_idx_q;
          end else begin
            if (beats_max) begin
              run_max_d = out_w_q;
              run_idx_d = out_idx_q;
            end
            row_d      = nxt_row;
            col_d      = nxt_col;
            out_idx_d  = nxt_idx;
            out_last_d = (nxt_idx == LAST_IDX);
            out_w_d    = tnorm(mu_t_q[nxt_row*W +: W], mu_d_q[nxt_col*W +: W], mode_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mu_t_q      <= '0;
      mu_d_q      <= '0;
      mode_q      <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_w_q     <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      w_max_q     <= '0;
      idx_max_q   <= '0;
    end else begin
      state_q     <= state_d;
      mu_t_q      <= mu_t_d;
      mu_d_q      <= mu_d_d;
      mode_q      <= mode_d;
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_w_q     <= out_w_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      w_max_q     <= w_max_d;
      idx_max_q   <= idx_max_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_w     = out_w_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign w_max     = w_max_q;
  assign idx_max   = idx_max_q;
  assign dbg_state = (state_q == S_RUN);

endmodule

// File: tb/tb_rule_eval_seq.sv
// Bench for rule_eval_seq (W=16, NT=ND=3): directed vector table, hand-written
// reset / back-to-back sequences and random snapshots checked against a
// behavioural model of the rule grid.
module tb_rule_eval_seq;
  localparam int W  = 16;
  localparam int NT = 3;
  localparam int ND = 3;
  localparam int IW = 4;
  localparam int NR = NT * ND;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [NT*W-1:0] muT = '0;
  logic [ND*W-1:0] muD = '0;
  logic            mode = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [W-1:0]    out_w;
  logic [IW-1:0]   out_idx;
  logic            out_last;
  logic [W-1:0]    w_max;
  logic [IW-1:0]   idx_max;
  logic            dbg_state;

  always #5 clk = ~clk;

  rule_eval_seq #(.W(W), .NT(NT), .ND(ND), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .muT(muT), .muD(muD), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_w(out_w), .out_idx(out_idx),
    .out_last(out_last), .w_max(w_max), .idx_max(idx_max),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            failures = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_max;
  logic [IW-1:0] exp_idx;
  logic [W-1:0]  prev_max = '0;
  logic [IW-1:0] prev_idx = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: weight of rule idx is tnorm(clamp(muT[idx/ND]), clamp(muD[idx%ND])).
  function automatic void model(input logic [NT*W-1:0] mt, input logic [ND*W-1:0] md,
                                input logic m);
    int a, b, w, best, bidx;
    exp_q.delete();
    best = -1;
    bidx = 0;
    for (int idx = 0; idx < NR; idx++) begin
      a = int'(mt[(idx / ND) * W +: W]);
      b = int'(md[(idx % ND) * W +: W]);
      if (a > 32768) a = 32768;
      if (b > 32768) b = 32768;
      w = m ? (a * b) / 32768 : ((a < b) ? a : b);
      exp_q.push_back(w[W-1:0]);
      if (w > best) begin
        best = w;
        bidx = idx;
      end
    end
    exp_max = best[W-1:0];
    exp_idx = bidx[IW-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  // Called 1 time unit after a rising edge with the DUT idle.
  task automatic offer(input logic [NT*W-1:0] mt, input logic [ND*W-1:0] md,
                       input logic m, input bit keep);
    chk("ready_before_offer", in_ready, 1);
    in_valid = 1'b1;
    muT = mt;
    muD = md;
    mode = m;
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
    muT = ~mt;  // scrambled inputs must not reach the captured snapshot
    muD = ~md;
    mode = ~m;
    chk("first_valid", out_valid, 1);
    chk("first_idx", out_idx, 0);
    chk("busy_not_ready", in_ready, 0);
  endtask

  // Consumes one snapshot, optionally stalling st_len cycles at rule st_at.
  task automatic collect(input int st_at, input int st_len);
    int beats = 0;
    int guard = 0;
    int stalled = 0;
    logic [W-1:0] hold_w = '0;
    logic [W-1:0] ew;
    while (beats < NR && guard < 300) begin
      if (out_valid) begin
        if (int'(out_idx) == st_at && stalled > 0) begin
          chk("hold_w", out_w, hold_w);
          chk("hold_idx", out_idx, st_at);
        end
        if (beats == 4) chk("w_max_hold", w_max, prev_max);
        if (int'(out_idx) == st_at && stalled < st_len) begin
          if (stalled == 0) hold_w = out_w;
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = 1'b1;
          ew = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hdead;
          chk("beat_idx", out_idx, beats);
          chk("beat_w", out_w, ew);
          chk("beat_last", out_last, (beats == NR - 1));
          beats++;
        end
      end else begin
        chk("no_bubble", out_valid, 1);
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b1;
    chk("beat_count", beats, NR);
    chk("done_valid", out_valid, 0);
    chk("done_ready", in_ready, 1);
    chk("w_max", w_max, exp_max);
    chk("idx_max", idx_max, exp_idx);
    prev_max = exp_max;
    prev_idx = exp_idx;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [NT*W-1:0] mt;
    logic [ND*W-1:0] md;
    logic            m;
    logic [W-1:0]    ew[NR];
    logic [W-1:0]    emax;
    logic [IW-1:0]   eidx;
    int              st_at;
    int              st_len;
  } vec_t;

  vec_t tbl[5];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [NT*W-1:0] mt;
    logic [ND*W-1:0] md;
    logic m;
    int g;

    // min, with a 3-cycle stall on rule 4
    tbl[0].mt = {16'h2000, 16'h6000, 16'h0000};
    tbl[0].md = {16'h0000, 16'h4000, 16'h4000};
    tbl[0].m = 1'b0;
    tbl[0].ew = '{16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h4000,
                  16'h0000, 16'h2000, 16'h2000, 16'h0000};
    tbl[0].emax = 16'h4000; tbl[0].eidx = 4'd3; tbl[0].st_at = 4; tbl[0].st_len = 3;
    // product on the same memberships
    tbl[1].mt = tbl[0].mt;
    tbl[1].md = tbl[0].md;
    tbl[1].m = 1'b1;
    tbl[1].ew = '{16'h0000, 16'h0000, 16'h0000, 16'h3000, 16'h3000,
                  16'h0000, 16'h1000, 16'h1000, 16'h0000};
    tbl[1].emax = 16'h3000; tbl[1].eidx = 4'd3; tbl[1].st_at = -1; tbl[1].st_len = 0;
    // clamp + saturation: every product equals ONE, tie keeps rule 0
    tbl[2].mt = '1;
    tbl[2].md = '1;
    tbl[2].m = 1'b1;
    tbl[2].ew = '{default: 16'h8000};
    tbl[2].emax = 16'h8000; tbl[2].eidx = 4'd0; tbl[2].st_at = 0; tbl[2].st_len = 1;
    // min with clamped operands; tie between rules 1,2,4,... keeps 1
    tbl[3].mt = '1;
    tbl[3].md = {16'h8000, 16'h9000, 16'h1234};
    tbl[3].m = 1'b0;
    tbl[3].ew = '{16'h1234, 16'h8000, 16'h8000, 16'h1234, 16'h8000,
                  16'h8000, 16'h1234, 16'h8000, 16'h8000};
    tbl[3].emax = 16'h8000; tbl[3].eidx = 4'd1; tbl[3].st_at = 8; tbl[3].st_len = 2;
    // all-zero weights: max 0 at rule 0
    tbl[4].mt = '0;
    tbl[4].md = '1;
    tbl[4].m = 1'b1;
    tbl[4].ew = '{default: 16'h0000};
    tbl[4].emax = 16'h0000; tbl[4].eidx = 4'd0; tbl[4].st_at = -1; tbl[4].st_len = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_w", out_w, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_w_max", w_max, 0);
    chk("rst_idx_max", idx_max, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    for (int k = 0; k < 5; k++) begin
      exp_q.delete();
      for (int r = 0; r < NR; r++) exp_q.push_back(tbl[k].ew[r]);
      exp_max = tbl[k].emax;
      exp_idx = tbl[k].eidx;
      offer(tbl[k].mt, tbl[k].md, tbl[k].m, 1'b0);
      collect(tbl[k].st_at, tbl[k].st_len);
    end

    // reset in the middle of a snapshot (at rule 5)
    model(tbl[0].mt, tbl[0].md, 1'b0);
    offer(tbl[0].mt, tbl[0].md, 1'b0, 1'b0);
    g = 0;
    while (out_idx != 4'd5 && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    chk("reach_idx5", out_idx, 5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_w_max", w_max, 0);
    chk("abort_idx_max", idx_max, 0);
    chk("abort_idx", out_idx, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_no_beat", out_valid, 0);
    prev_max = '0;
    prev_idx = '0;
    model(tbl[1].mt, tbl[1].md, 1'b1);
    offer(tbl[1].mt, tbl[1].md, 1'b1, 1'b0);
    collect(-1, 0);

    // in_valid held across completion: the held offer is taken right after
    model(tbl[3].mt, tbl[3].md, 1'b0);
    offer(tbl[3].mt, tbl[3].md, 1'b0, 1'b1);
    muT = tbl[1].mt;
    muD = tbl[1].md;
    mode = 1'b1;
    collect(2, 2);
    model(tbl[1].mt, tbl[1].md, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_idx", out_idx, 0);
    chk("b2b_busy", in_ready, 0);
    collect(-1, 0);

    // random snapshots against the model
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < NT; k++)
        mt[k*W +: W] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(32768, 65535))
                                                    : 16'($urandom_range(0, 32768));
      for (int k = 0; k < ND; k++)
        md[k*W +: W] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(32768, 65535))
                                                    : 16'($urandom_range(0, 32768));
      m = 1'($urandom_range(0, 1));
      model(mt, md, m);
      offer(mt, md, m, 1'b0);
      // stray in_valid pulse while busy must be ignored
      in_valid = 1'b1;
      muT = '0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      // first beat was presented at the accept cycle; out_ready stayed high
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      collect_tail(int'($urandom_range(1, 12)), int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Variant of collect for when rule 0 has already been handed over.
  task automatic collect_tail(input int st_at, input int st_len);
    int beats = 1;
    int guard = 0;
    int stalled = 0;
    logic [W-1:0] hold_w = '0;
    logic [W-1:0] ew;
    while (beats < NR && guard < 300) begin
      if (out_valid) begin
        if (int'(out_idx) == st_at && stalled > 0) chk("rnd_hold_w", out_w, hold_w);
        if (int'(out_idx) == st_at && stalled < st_len) begin
          if (stalled == 0) hold_w = out_w;
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = 1'b1;
          ew = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hdead;
          chk("rnd_idx", out_idx, beats);
          chk("rnd_w", out_w, ew);
          chk("rnd_last", out_last, (beats == NR - 1));
          beats++;
        end
      end else begin
        chk("rnd_no_bubble", out_valid, 1);
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b1;
    chk("rnd_count", beats, NR);
    chk("rnd_done_valid", out_valid, 0);
    chk("rnd_w_max", w_max, exp_max);
    chk("rnd_idx_max", idx_max, exp_idx);
    prev_max = exp_max;
    prev_idx = exp_idx;
  endtask

endmodule
